ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ALU execute stage with a two-entry output buffer (OUT + SKID); one cycle from accept to out_valid.
// Backpressure: in_ready is registered and drops only when both OUT and SKID hold beats; flush empties the stage.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            is_branch_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            branch_taken,
  output logic            illegal,
  output logic [7:0]      illegal_count
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [4:0]      rd;
    logic            reg_write;
    logic            branch_taken;
    logic            illegal;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  beat_t           new_beat, out_q, skid_q;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            in_ready_q;
  logic [7:0]      ill_cnt_q;
  logic            accept, xfer;
  logic            load_out_new, load_out_skid, load_skid;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_ill = 1'b1;
    endcase
  end

  // An illegal beat still flows through so downstream sees the flag, but it must not write back or branch.
  always_comb begin
    new_beat.result       = alu_res;
    new_beat.zero         = (alu_res == '0);
    new_beat.rd           = rd_in;
    new_beat.reg_write    = reg_write_in & ~alu_ill;
    new_beat.branch_taken = is_branch_in & (alu_res == '0) & ~alu_ill;
    new_beat.illegal      = alu_ill;
  end

  assign accept    = in_valid & in_ready_q & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_out_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_d       = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      ill_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (accept && new_beat.illegal && (ill_cnt_q != 8'hFF)) begin
        ill_cnt_q <= ill_cnt_q + 8'd1;
      end
    end
  end

  // Payload needs no reset: it is only observed while the matching state says it is valid.
  always_ff @(posedge clk) begin
    if (load_out_new) begin
      out_q <= new_beat;
    end else if (load_out_skid) begin
      out_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= new_beat;
    end
  end

  assign in_ready      = in_ready_q;
  assign illegal_count = ill_cnt_q;
  assign result        = out_q.result;
  assign zero          = out_q.zero;
  assign rd_out        = out_q.rd;
  assign reg_write_out = out_q.reg_write;
  assign branch_taken  = out_q.branch_taken;
  assign illegal       = out_q.illegal;

endmodule
